// File: rtl/regfile_multiport.sv
// Multi-port general-purpose register file with a post-reset clear sequencer.
// Reads are combinational; writes, clear and control state update on the rising edge.
// Entry 0 can be hardwired to zero, and a same-cycle write can be forwarded to readers.
module regfile_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    output logic                     busy,
    output logic                     wr_drop
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic                wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    // Writes to entry 0 are silently discarded when it is the hardwired zero register.
    logic                wr_to_zero;
    assign wr_to_zero = (ZERO_REG != 0) && (wa == '0);

    // Next-state logic for the clear sequencer and the sticky dropped-write flag.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_drop_d = wr_drop_q;
        if (state_q == ST_CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (we) begin
                wr_drop_d = 1'b1;
            end
            if (clr_ptr_q == LAST_PTR) begin
                state_d   = ST_RUN;
                clr_ptr_d = '0;
            end
        end
    end

    // Control state: async reset restarts the clear from entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // Single memory write port, shared between the clear sequencer and the core.
    always_comb begin
        mem_wen   = 1'b0;
        mem_waddr = wa;
        mem_wdata = wd;
        if (state_q == ST_CLEAR) begin
            mem_wen   = 1'b1;
            mem_waddr = clr_ptr_q;
            mem_wdata = '0;
        end else if (we && !wr_to_zero) begin
            mem_wen   = 1'b1;
        end
    end

    // Storage array; contents are defined by the clear sequence, not by reset.
    always_ff @(posedge clk) begin
        if (mem_wen) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign busy    = (state_q == ST_CLEAR);
    assign wr_drop = wr_drop_q;

    // One combinational read path per port.
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_k;
        logic [DATA_W-1:0] rd_k;

        assign ra_k = ra[k*ADDR_W +: ADDR_W];

        // Read mux: clear masks everything, zero register beats bypass, bypass beats storage.
        always_comb begin
            rd_k = mem_q[ra_k];
            if (state_q == ST_CLEAR) begin
                rd_k = '0;
            end else if ((ZERO_REG != 0) && (ra_k == '0)) begin
                rd_k = '0;
            end else if ((BYPASS != 0) && we && (ra_k == wa)) begin
                rd_k = wd;
            end
        end

        assign rd[k*DATA_W +: DATA_W] = rd_k;
    end

endmodule
